vc_read_scheduler: RTL
======================

Name: vc_read_scheduler

Overview:
Per-input-port controller that sequences reads from the port's VC_NUM input buffers, one per virtual channel. It tracks packet state per VC (IDLE -> WAIT_VA -> ACTIVE) and raises VC-allocation requests for waiting head flits. It issues the port's switch-allocation request and, on grant, round-robins the single crossbar read slot among eligible VCs. It sits between the input buffers and the VC/switch allocators.

Parameters:
VC_NUM, 2, number of virtual channels (input buffers) on this port; power of two, 2..8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
is_empty_i  in  VC_NUM  per-VC buffer empty
is_head_i  in  VC_NUM  front flit of VC v is HEAD or HEADTAIL; valid only when not empty
is_tail_i  in  VC_NUM  front flit of VC v is TAIL or HEADTAIL; valid only when not empty
va_grant_i  in  VC_NUM  one-cycle pulse: VC allocator assigned a downstream VC to input VC v
downstream_on_i  in  VC_NUM  on/off flow control of the downstream VC held by input VC v (1 = may send)
sa_grant_i  in  1  switch allocator grants this port one flit transfer this cycle
va_request_o  out  VC_NUM  VC v requests VC allocation
sa_request_o  out  1  at least one VC eligible to send
read_o  out  VC_NUM  one-hot (or zero) read strobe to input buffer v
active_o  out  VC_NUM  VC v in ACTIVE state
err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: all VC states IDLE, rr_ptr=0, err_o=0. While rst=1, all outputs are forced to 0 (read_o=0, va_request_o=0, sa_request_o=0, active_o=0, err_o=0).
- Per-VC FSM, all transitions registered:
  - IDLE: if !is_empty_i[v] and is_head_i[v], go to WAIT_VA next cycle.
  - IDLE: if !is_empty_i[v] and !is_head_i[v], stay in IDLE and set err_o=1.
  - WAIT_VA: va_request_o[v]=1, decoded combinationally from state. va_grant_i[v]=1 moves the VC to ACTIVE next cycle.
  - va_grant_i[v] in any state other than WAIT_VA is ignored; no error.
  - ACTIVE: active_o[v]=1. If read_o[v]=1 and is_tail_i[v]=1, go to IDLE next cycle. Otherwise stay.
- Eligibility: eligible[v] = ACTIVE & !is_empty_i[v] & downstream_on_i[v]. sa_request_o = OR of eligible, combinational.
- Read selection: when sa_grant_i=1 and sa_request_o=1, read_o is one-hot of the first eligible VC searching from rr_ptr upward, modulo VC_NUM. Same-cycle, zero-latency combinational path from sa_grant_i to read_o.
- When sa_grant_i=0, read_o=0. sa_grant_i=1 with sa_request_o=0 gives read_o=0 and is not an error.
- rr_ptr: after a read from VC v, rr_ptr <= (v+1) mod VC_NUM. It is unchanged on cycles with no read. Width is clog2(VC_NUM).
- Arbitration is per flit: interleaving flits of different VCs is legal.
- HEADTAIL (single-flit packet): IDLE -> WAIT_VA -> ACTIVE. Its one read returns the VC to IDLE.
- ACTIVE with empty buffer or downstream off: VC stays ACTIVE, not eligible, and loses no state.
- Back-to-back packets: after a tail read the VC spends one cycle in IDLE, then sees the next head.
- Reset mid-packet: state is dropped. Buffer contents are the buffer's own concern.
- err_o is cleared only by rst.

Test Plan:
- Reset: hold rst=1 for 2 cycles with is_empty_i=2'b00, is_head_i=2'b11, sa_grant_i=1 -> all outputs 0 throughout; first cycle after release va_request_o=2'b00; second cycle va_request_o=2'b11.
- Single packet on VC0: 4 flits queued, head visible at cycle 0 -> va_request_o=01 from cycle 1. va_grant_i=01 at cycle 3 -> active_o=01, sa_request_o=1 at cycle 4. sa_grant_i held high, is_tail_i[0] on the 4th flit -> read_o=01 for cycles 4-7. Cycle 8: active_o=00, sa_request_o=0.
- Round-robin: both VCs ACTIVE and non-empty, sa_grant_i=1 continuously, rr_ptr=0 -> read_o sequence 01,10,01,10.
- Flow control: as above with downstream_on_i=2'b10 -> read_o=10 every cycle. Set downstream_on_i=11 after a VC1 read -> next read_o=01, then alternation resumes.
- Bubble and grant gating: VC0 ACTIVE, is_empty_i[0]=1 for one cycle -> read_o=0 and active_o[0]=1 that cycle. sa_grant_i=0 with VC eligible -> read_o=0 and rr_ptr unchanged.
- Errors and mid-packet reset: VC1 IDLE with non-head front flit -> err_o=1 next cycle and stays 1. Assert rst for 1 cycle mid-packet -> err_o=0, active_o=00, rr_ptr=0; a head presented afterwards restarts the FSM normally.

Source files
------------

// File: rtl/vc_read_scheduler.sv
// Per-input-port read sequencer: per-VC packet FSM, VC-allocation requests, and a
// round-robin pick of one eligible VC for the crossbar slot on each switch grant.
module vc_read_scheduler #(
   parameter int unsigned VC_NUM = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [VC_NUM-1:0] is_empty_i,
   input  logic [VC_NUM-1:0] is_head_i,
   input  logic [VC_NUM-1:0] is_tail_i,
   input  logic [VC_NUM-1:0] va_grant_i,
   input  logic [VC_NUM-1:0] downstream_on_i,
   input  logic              sa_grant_i,
   output logic [VC_NUM-1:0] va_request_o,
   output logic              sa_request_o,
   output logic [VC_NUM-1:0] read_o,
   output logic [VC_NUM-1:0] active_o,
   output logic              err_o
);

   localparam int unsigned PtrW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StWaitVa = 2'd1;
   localparam logic [1:0] StActive = 2'd2;

   logic [1:0]      state_q [VC_NUM];
   logic [1:0]      state_d [VC_NUM];
   logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
   logic            err_q, err_d;

   logic [VC_NUM-1:0] eligible;
   logic [VC_NUM-1:0] read;
   logic [PtrW-1:0]   idx;
   logic [PtrW-1:0]   read_idx;
   logic              found;
   logic              read_fire;

   // Rotating priority search starting at rr_ptr; VC_NUM is a power of two so the
   // index wraps naturally in PtrW bits.
   always_comb begin
      eligible = '0;
      read     = '0;
      idx      = '0;
      read_idx = '0;
      found    = 1'b0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         eligible[v] = (state_q[v] == StActive) && !is_empty_i[v] && downstream_on_i[v];
      end
      for (int unsigned i = 0; i < VC_NUM; i++) begin
         idx = rr_ptr_q + PtrW'(i);
         if (!found && eligible[idx]) begin
            found    = 1'b1;
            read_idx = idx;
         end
      end
      read_fire = sa_grant_i && found && !rst;
      if (read_fire) begin
         read[read_idx] = 1'b1;
      end
   end

   always_comb begin
      err_d    = err_q;
      rr_ptr_d = read_fire ? (read_idx + PtrW'(1)) : rr_ptr_q;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
         case (state_q[v])
            StIdle: begin
               if (!is_empty_i[v]) begin
                  if (is_head_i[v]) begin
                     state_d[v] = StWaitVa;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StWaitVa: begin
               if (va_grant_i[v]) begin
                  state_d[v] = StActive;
               end
            end
            StActive: begin
               if (read[v] && is_tail_i[v]) begin
                  state_d[v] = StIdle;
               end
            end
            default: state_d[v] = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned v = 0; v < VC_NUM; v++) begin
            state_q[v] <= StIdle;
         end
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int unsigned v = 0; v < VC_NUM; v++) begin
            state_q[v] <= state_d[v];
         end
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   // Reset is synchronous, so outputs are masked while rst is high to hide stale state.
   always_comb begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         va_request_o[v] = !rst && (state_q[v] == StWaitVa);
         active_o[v]     = !rst && (state_q[v] == StActive);
      end
      sa_request_o = !rst && (|eligible);
      read_o       = read;
      err_o        = !rst && err_q;
   end

endmodule
